// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time programmer for the writable instruction memory. A byte stream
//   arrives over a valid/ready handshake. The stream carries:
//     - a word-count header,
//     - the instruction words, little-endian,
//     - an XOR checksum byte.
//   The words are written to consecutive addresses starting at 0. The core is
//   held in reset until an image has been loaded and its checksum verified.
//
// Ports
//   clk        clock, rising-edge active
//   reset      synchronous, active-high reset
//   start      request a new load; honoured only in DONE and ERR
//   rx_valid   source presents a byte on rx_data
//   rx_data    stream byte
//   rx_ready   loader accepts a byte this cycle
//   we         instruction memory write enable (one pulse per word)
//   waddr      instruction memory write address
//   wdata      instruction memory write data
//   cpu_reset  holds the processor core in reset
//   done       image loaded and checksum verified
//   err        load aborted (bad header or checksum mismatch)

module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [N-1:0]  wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);

  localparam int              LANES     = N / 8;
  localparam int              BW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BW-1:0]   LAST_LANE = BW'(LANES - 1);
  localparam logic [31:0]     CAPACITY  = 32'd1 << AW;

  typedef enum logic [2:0] {HDR, DATA, WRITE, CHK, DONE, ERR} state_t;

  state_t        state;
  logic [AW:0]   count;
  logic [7:0]    csum;
  logic [BW-1:0] byte_idx;
  logic          accept;
  logic [31:0]   hdr_ext;
  logic          last_word;

  assign accept    = rx_valid && rx_ready;
  // Widened header byte so the capacity check also works when 2^AW > 255.
  assign hdr_ext   = {24'd0, rx_data};
  // count holds AW+1 bits, so count-1 still fits beside a zero-extended waddr.
  assign last_word = ({1'b0, waddr} == (count - 1'b1));

  // Main loader state machine. The assembled word register doubles as wdata,
  // so wdata and waddr are both registered and stable during the WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR;
      count    <= '0;
      csum     <= '0;
      byte_idx <= '0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      case (state)
        HDR: begin
          if (accept) begin
            if (hdr_ext == 32'd0 || hdr_ext > CAPACITY) begin
              state <= ERR;
            end else begin
              count    <= hdr_ext[AW:0];
              waddr    <= '0;
              byte_idx <= '0;
              csum     <= rx_data;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
            csum <= csum ^ rx_data;
            if (byte_idx == LAST_LANE) begin
              state <= WRITE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          byte_idx <= '0;
          if (last_word) begin
            state <= CHK;
          end else begin
            waddr <= waddr + 1'b1;
            state <= DATA;
          end
        end
        CHK: begin
          if (accept) begin
            state <= (rx_data == csum) ? DONE : ERR;
          end
        end
        DONE, ERR: begin
          if (start) begin
            state <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

  // Handshake and status outputs are pure decodes of the registered state.
  assign rx_ready  = (state == HDR) || (state == DATA) || (state == CHK);
  assign we        = (state == WRITE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign cpu_reset = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Randomized self-checking bench for imem_loader (N=32, AW=6).
//   - A reference model parses each byte stream from the protocol rules:
//     header, little-endian words, and XOR checksum.
//   - From that parse it predicts the memory writes and the final status.
//   - A negedge monitor captures every we pulse for comparison.

module tb_imem_loader;

  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          cpu_reset;
  logic          done;
  logic          err;

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  int          nChecks = 0;
  int          nFail   = 0;
  int          cyc     = 0;
  bit          monOn   = 0;

  logic [7:0]  streamQ[$];
  logic [31:0] wordsQ[$];
  logic [5:0]  expWaddr[$];
  logic [31:0] expWdata[$];
  logic [5:0]  gotWaddr[$];
  logic [31:0] gotWdata[$];
  int          gotCyc[$];
  bit          expDone;
  int          nSend;

  // Free-running clock and cycle counter
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every write pulse.
  // While loading, rx_ready must be low exactly in the write cycle.
  always @(negedge clk) begin
    if (we) begin
      gotWaddr.push_back(waddr);
      gotWdata.push_back(wdata);
      gotCyc.push_back(cyc);
    end
    if (monOn && !done && !err)
      checkOutput("ready_vs_we", {63'd0, rx_ready}, {63'd0, !we});
  end

  // Reference model: interpret streamQ by the protocol rules
  task automatic predict();
    int c;
    logic [7:0] cs;
    expWaddr.delete();
    expWdata.delete();
    c = int'(streamQ[0]);
    if (c == 0 || c > (1 << AW)) begin
      expDone = 0;
      nSend   = 1;
    end else begin
      cs = streamQ[0];
      for (int w = 0; w < c; w++) begin
        expWaddr.push_back(6'(w));
        expWdata.push_back({streamQ[4*w+4], streamQ[4*w+3], streamQ[4*w+2], streamQ[4*w+1]});
      end
      for (int i = 1; i <= 4*c; i++) cs = cs ^ streamQ[i];
      expDone = (streamQ[4*c+1] == cs);
      nSend   = 4*c + 2;
    end
  endtask

  // Build a stream from wordsQ, optionally with a corrupted checksum
  task automatic buildStream(input bit badSum);
    logic [7:0] cs;
    logic [7:0] b;
    streamQ.delete();
    cs = 8'(wordsQ.size());
    streamQ.push_back(cs);
    for (int i = 0; i < wordsQ.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b = wordsQ[i][8*k +: 8];
        streamQ.push_back(b);
        cs = cs ^ b;
      end
    end
    streamQ.push_back(badSum ? cs + 8'd1 : cs);
  endtask

  // Present one byte starting at a negedge.
  // Returns at the negedge after the edge that accepted it.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int waitCnt;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 0;
        @(negedge clk);
      end
    end
    rx_valid = 1;
    rx_data  = b;
    waitCnt  = 0;
    while (!rx_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rx_ready) checkOutput("rx_timeout", 64'd0, 64'd1);
    else @(negedge clk);
  endtask

  task automatic clearGot();
    gotWaddr.delete();
    gotWdata.delete();
    gotCyc.delete();
  endtask

  task automatic compareWrites(input int upTo);
    checkOutput("we_count", 64'(gotWaddr.size()), 64'(upTo));
    for (int i = 0; i < upTo && i < gotWaddr.size(); i++) begin
      checkOutput("waddr", 64'(gotWaddr[i]), 64'(expWaddr[i]));
      checkOutput("wdata", 64'(gotWdata[i]), 64'(expWdata[i]));
    end
  endtask

  // Send the whole stream and check writes and final status.
  // startIdx selects a byte sent with start held high (-1 for none).
  task automatic applyStimulus(input bit gaps, input int startIdx);
    predict();
    clearGot();
    for (int i = 0; i < nSend; i++) begin
      start = (i == startIdx);
      sendByte(streamQ[i], gaps);
    end
    start    = 0;
    rx_valid = 0;
    checkOutput("done", {63'd0, done}, {63'd0, expDone});
    checkOutput("err", {63'd0, err}, {63'd0, !expDone});
    checkOutput("cpu_reset", {63'd0, cpu_reset}, {63'd0, !expDone});
    checkOutput("rx_ready_end", {63'd0, rx_ready}, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("rx_ready_hold", {63'd0, rx_ready}, 64'd0);
    compareWrites(expWaddr.size());
    if (!gaps) begin
      for (int k = 1; k < gotCyc.size(); k++)
        checkOutput("we_spacing", 64'(gotCyc[k] - gotCyc[k-1]), 64'd5);
    end
  endtask

  // Pulse start with a byte on the bus; the byte must not be taken
  task automatic pulseStart();
    start    = 1;
    rx_valid = 1;
    rx_data  = 8'h00;
    @(negedge clk);
    start    = 0;
    rx_valid = 0;
    checkOutput("start_hdr_ready", {63'd0, rx_ready}, 64'd1);
    checkOutput("start_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    checkOutput("start_done", {63'd0, done}, 64'd0);
    checkOutput("start_err", {63'd0, err}, 64'd0);
  endtask

  initial begin
    reset    = 1;
    start    = 0;
    rx_valid = 0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    checkOutput("rst_we", {63'd0, we}, 64'd0);
    checkOutput("rst_waddr", 64'(waddr), 64'd0);
    checkOutput("rst_wdata", 64'(wdata), 64'd0);
    checkOutput("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);
    reset = 0;
    monOn = 1;

    // Two-word reference stream
    $display("[TB] two-word load");
    streamQ = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hf8, 8'h01, 8'h80, 8'h00, 8'hf8, 8'h83};
    applyStimulus(1, -1);
    checkOutput("t1_wdata0", 64'(gotWdata.size() > 0 ? gotWdata[0] : 32'h0), 64'hf8000000);
    checkOutput("t1_wdata1", 64'(gotWdata.size() > 1 ? gotWdata[1] : 32'h0), 64'hf8008001);
    checkOutput("t1_done", {63'd0, done}, 64'd1);

    // Same stream with a bad checksum, then a good one after start
    $display("[TB] bad checksum");
    pulseStart();
    streamQ[9] = 8'h84;
    applyStimulus(1, -1);
    checkOutput("t2_err", {63'd0, err}, 64'd1);
    pulseStart();
    streamQ[9] = 8'h83;
    applyStimulus(0, -1);

    // Bad headers: too large and zero
    $display("[TB] bad headers");
    pulseStart();
    streamQ = '{8'h41};
    applyStimulus(0, -1);
    pulseStart();
    streamQ = '{8'h00};
    applyStimulus(1, -1);

    // Full-capacity load with random gaps
    $display("[TB] full 64-word load");
    pulseStart();
    wordsQ.delete();
    for (int i = 0; i < 64; i++) wordsQ.push_back($urandom());
    buildStream(0);
    applyStimulus(1, -1);

    // Reset after two bytes of word 2
    $display("[TB] reset mid-load");
    pulseStart();
    wordsQ.delete();
    for (int i = 0; i < 5; i++) wordsQ.push_back($urandom());
    buildStream(0);
    predict();
    clearGot();
    for (int i = 0; i < 11; i++) sendByte(streamQ[i], 1);
    reset    = 1;
    rx_valid = 0;
    @(negedge clk);
    reset = 0;
    checkOutput("mid_rx_ready", {63'd0, rx_ready}, 64'd1);
    checkOutput("mid_we", {63'd0, we}, 64'd0);
    checkOutput("mid_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    checkOutput("mid_done", {63'd0, done}, 64'd0);
    checkOutput("mid_err", {63'd0, err}, 64'd0);
    repeat (4) @(negedge clk);
    compareWrites(2);
    wordsQ.delete();
    for (int i = 0; i < 3; i++) wordsQ.push_back($urandom());
    buildStream(0);
    applyStimulus(1, -1);

    // Back-to-back stream with start pulsed during DATA
    $display("[TB] back-to-back with stray start");
    pulseStart();
    wordsQ.delete();
    for (int i = 0; i < 4; i++) wordsQ.push_back($urandom());
    buildStream($urandom_range(0, 1) == 1);
    applyStimulus(0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory programmer for the pipelined processor. It receives a byte stream over a valid/ready interface, assembles it into N-bit instruction words, and writes them sequentially into the writable instruction memory starting at address 0. The stream is a header (word count), the words, and an XOR checksum. The loader holds the processor core in reset from power-up until an image has been loaded and verified.

## Interface

Parameters:
- N, 32: instruction word width; must be a multiple of 8.
- AW, 6: instruction memory address width; capacity is 2^AW words.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a new load; honoured only in DONE and ERR.
- rx_valid  input  1  the source presents a byte on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  the loader can accept a byte this cycle.
- we  output  1  instruction memory write enable; one-cycle pulse per word.
- waddr  output  AW  instruction memory write address.
- wdata  output  N  instruction memory write data.
- cpu_reset  output  1  holds the processor core in reset.
- done  output  1  image loaded and checksum verified.
- err  output  1  load aborted because of a bad header or checksum mismatch.

## Operation

- Handshake: a byte is accepted on any rising edge where rx_valid && rx_ready. rx_data is ignored otherwise.
- State machine states: HDR, DATA, WRITE, CHK, DONE, ERR.
- HDR (rx_ready=1):
  - The accepted byte c is the word count.
  - If c==0 or c>2^AW, go to ERR.
  - Otherwise latch count=c, clear the word address and byte index, set csum=c, and go to DATA.
- DATA (rx_ready=1):
  - The accepted byte goes to lane byte_idx of the word shift register, little-endian: the first byte lands in bits 7:0.
  - csum ^= byte.
  - On acceptance of byte N/8-1, go to WRITE.
- WRITE (rx_ready=0, we=1):
  - waddr is the current word address; wdata is the assembled word.
  - Next: if waddr==count-1, go to CHK; otherwise increment the address, clear byte_idx, and go to DATA.
- CHK (rx_ready=1):
  - If the accepted byte equals csum, go to DONE; otherwise go to ERR.
- DONE (rx_ready=0): done=1, cpu_reset=0. A start pulse sends the machine to HDR, with cpu_reset=1 again from the next cycle.
- ERR (rx_ready=0): err=1, cpu_reset=1. A start pulse sends the machine to HDR.
- start is ignored in HDR, DATA, WRITE and CHK.
- Output decoding:
  - rx_ready, we, done, err and cpu_reset are decoded from the registered state only (glitch-free).
  - cpu_reset=1 in every state except DONE.
  - waddr and wdata are registered.
- Memory words that were written before an ERR are not cleared; the core simply stays in reset.
- Arithmetic:
  - The address counter is AW bits and never wraps, because count ≤ 2^AW.
  - The count register is AW+1 bits, so that 2^AW words can be represented.
  - csum is 8 bits and covers the header byte and all data bytes; the checksum byte itself is excluded.

## Timing

- Reset values: state=HDR, rx_ready=1, we=0, waddr=0, wdata=0, cpu_reset=1, done=0, err=0, csum=0, byte_idx=0.
- Reset mid-operation: in the cycle after reset, the machine is in HDR. Any partial word is discarded and no we is issued for it.
- Write latency: we is asserted in the cycle immediately after the edge that accepts the last byte of a word.
- Throughput: with rx_valid held high, each word takes N/8+1 cycles. rx_ready is low only in the single WRITE cycle.
- done/err latency: done or err asserts in the cycle after the edge that accepts the checksum byte. For a bad header, err asserts in the cycle after the header byte is accepted.
- start while rx_valid=1 in DONE or ERR: the next cycle is HDR. No byte is accepted in the start cycle, because rx_ready=0.
- reset has priority over start and over a handshake in the same cycle.

## Test plan

1. Two-word load, N=32:
   - Stimulus: bytes 02, 00 00 00 f8, 01 80 00 f8, checksum 83.
   - Required: we pulses with (waddr 0, wdata f8000000) and (waddr 1, wdata f8008001). Then done=1 and cpu_reset=0.
2. Bad checksum:
   - Stimulus: the same stream with final byte 84.
   - Required: both writes still occur, then err=1 and cpu_reset=1.
   - Follow-up: a start pulse, then a correct stream, ends with done=1.
3. Bad header:
   - Stimulus: header 41 (65 > 64), or header 00.
   - Required: err=1 in the cycle after acceptance. No we pulse. rx_ready=0 until start.
4. Full 64-word load with random rx_valid gaps:
   - Required: exactly 64 we pulses with waddr 0..63 in order and wdata equal to the sent words. rx_ready is low only in WRITE cycles. done=1 at the end.
5. Reset mid-load:
   - Stimulus: reset asserted after 2 bytes of word index 2.
   - Required: HDR on the next cycle. No we for address 2. cpu_reset=1, done=0, err=0. A subsequent 3-word load completes correctly.
6. Back-to-back stream with rx_valid held high:
   - Required: exactly 5 cycles between consecutive we pulses (N=32).
   - Required: start asserted during DATA has no effect.
